// File: rtl/reg_file_sb.sv
// 8x16 register file with two combinational read ports, write-through bypass
// and a pending-write scoreboard that flags RAW/WAW hazards and stalls issue.
module reg_file_sb_rd #(
  parameter int NREG = 8,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic [AW-1:0]            ra,
  input  logic [NREG-1:0][DW-1:0]  regs,
  input  logic [NREG-1:0]          pend,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [DW-1:0]            wd,
  output logic [DW-1:0]            rd,
  output logic                     haz
);
  logic hit;

  always_comb begin
    hit = we && (wa == ra) && (ra != '0);
    rd  = '0;
    if (ra != '0) rd = hit ? wd : regs[ra];
    // a same-cycle write-back satisfies a pending read
    haz = (ra != '0) && pend[ra] && !hit;
  end
endmodule

module reg_file_sb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  RA1,
  input  logic [2:0]  RA2,
  output logic [15:0] RD1,
  output logic [15:0] RD2,
  input  logic [2:0]  WA,
  input  logic [15:0] WD,
  input  logic        WE,
  input  logic        ISSUE,
  input  logic [2:0]  ISSUE_A,
  output logic        HAZ1,
  output logic        HAZ2,
  output logic        STALL,
  output logic [7:0]  PEND
);
  localparam int NREG = 8;
  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NRD  = 2;

  logic [NREG-1:0][DW-1:0] regs_q, regs_d;
  logic [NREG-1:0]         pend_q, pend_d;
  logic [NRD-1:0][AW-1:0]  ra_v;
  logic [NRD-1:0][DW-1:0]  rd_v;
  logic [NRD-1:0]          haz_v;
  logic                    wr_ok, waw;

  assign ra_v = {RA2, RA1};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    reg_file_sb_rd #(.NREG(NREG), .DW(DW), .AW(AW)) u_rd (
      .ra   (ra_v[p]),
      .regs (regs_q),
      .pend (pend_q),
      .we   (WE),
      .wa   (WA),
      .wd   (WD),
      .rd   (rd_v[p]),
      .haz  (haz_v[p])
    );
  end

  always_comb begin
    wr_ok = WE && (WA != '0);
    waw   = ISSUE && pend_q[ISSUE_A] && !(WE && (WA == ISSUE_A));
    RD1   = rd_v[0];
    RD2   = rd_v[1];
    HAZ1  = haz_v[0];
    HAZ2  = haz_v[1];
    STALL = HAZ1 | HAZ2 | waw;
    PEND  = pend_q;
  end

  // write-back is never blocked by STALL; a same-register set overrides the clear
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[WA] = WD;
      pend_d[WA] = 1'b0;
    end
    if (ISSUE && (ISSUE_A != '0) && !STALL) pend_d[ISSUE_A] = 1'b1;
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against an
// array/bitmask reference model of the register file and scoreboard.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  RA1, RA2, WA, ISSUE_A;
  logic [15:0] WD, RD1, RD2;
  logic        WE, ISSUE, HAZ1, HAZ2, STALL;
  logic [7:0]  PEND;

  int vec  = 0;
  int errs = 0;

  logic [15:0] m_r [8];
  logic [7:0]  m_p;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WA(WA), .WD(WD), .WE(WE), .ISSUE(ISSUE), .ISSUE_A(ISSUE_A),
    .HAZ1(HAZ1), .HAZ2(HAZ2), .STALL(STALL), .PEND(PEND)
  );

  function automatic logic [15:0] exp_rd(input logic [2:0] ra);
    if (ra == 0) return 16'h0;
    if (WE && WA == ra) return WD;
    return m_r[ra];
  endfunction

  function automatic logic exp_haz(input logic [2:0] ra);
    return (ra != 0) && m_p[ra] && !(WE && WA == ra);
  endfunction

  function automatic logic exp_stall();
    return exp_haz(RA1) || exp_haz(RA2) ||
           (ISSUE && m_p[ISSUE_A] && !(WE && WA == ISSUE_A));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_p = 8'h0;
  endtask

  task automatic idle();
    WE = 0; WA = 0; WD = 0; ISSUE = 0; ISSUE_A = 0; RA1 = 0; RA2 = 0;
  endtask

  // one clock edge; the model follows the spec's update rules
  task automatic tick();
    logic st;
    st = exp_stall();
    @(posedge clk);
    if (rst_n) begin
      if (WE && WA != 0) begin
        m_r[WA] = WD;
        m_p[WA] = 1'b0;
      end
      if (ISSUE && ISSUE_A != 0 && !st) m_p[ISSUE_A] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    ISSUE = 1; ISSUE_A = 3; RA1 = 3; RA2 = 5;
    model_reset();
    #2;
    vec++; if (PEND !== 8'h00) begin errs++; $display("FAIL reset_pend got %h exp 00", PEND); end
    vec++; if (STALL !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", STALL); end
    vec++; if (RD1 !== 16'h0 || RD2 !== 16'h0) begin errs++; $display("FAIL reset_rd got %h/%h exp 0/0", RD1, RD2); end
    vec++; if (HAZ1 !== 1'b0 || HAZ2 !== 1'b0) begin errs++; $display("FAIL reset_haz got %b/%b exp 0/0", HAZ1, HAZ2); end
    @(negedge clk); idle(); rst_n = 1;
  endtask

  task automatic test_write_read();
    WE = 1; WA = 3; WD = 16'hBEEF;
    tick();
    WE = 0; RA1 = 3; RA2 = 0; #1;
    vec++; if (RD1 !== 16'hBEEF) begin errs++; $display("FAIL wr_rd1 got %h exp BEEF", RD1); end
    vec++; if (RD2 !== 16'h0000) begin errs++; $display("FAIL wr_rd2 got %h exp 0000", RD2); end
  endtask

  task automatic test_r0();
    WE = 1; WA = 0; WD = 16'h1234; RA1 = 0; #1;
    vec++; if (RD1 !== 16'h0000) begin errs++; $display("FAIL r0_bypass got %h exp 0000", RD1); end
    tick();
    WE = 0; #1;
    vec++; if (RD1 !== 16'h0000 || PEND[0] !== 1'b0) begin errs++; $display("FAIL r0_write got %h pend0 %b exp 0000/0", RD1, PEND[0]); end
  endtask

  task automatic test_bypass();
    WE = 1; WA = 5; WD = 16'h00AA; RA1 = 5; #1;
    vec++; if (RD1 !== 16'h00AA) begin errs++; $display("FAIL bypass got %h exp 00AA", RD1); end
    tick();
    WE = 0; WD = 16'hFFFF; #1;
    vec++; if (RD1 !== 16'h00AA) begin errs++; $display("FAIL bypass_stored got %h exp 00AA", RD1); end
  endtask

  task automatic test_hazard();
    idle(); ISSUE = 1; ISSUE_A = 2;
    tick();
    ISSUE = 0; RA1 = 2; WE = 0; #1;
    vec++; if (PEND !== 8'h04) begin errs++; $display("FAIL haz_pend got %h exp 04", PEND); end
    vec++; if (HAZ1 !== 1'b1 || STALL !== 1'b1) begin errs++; $display("FAIL haz_raw got %b/%b exp 1/1", HAZ1, STALL); end
    WE = 1; WA = 2; WD = 16'h7777; #1;
    vec++; if (HAZ1 !== 1'b0 || STALL !== 1'b0) begin errs++; $display("FAIL haz_wb got %b/%b exp 0/0", HAZ1, STALL); end
    tick();
    WE = 0; #1;
    vec++; if (PEND !== 8'h00) begin errs++; $display("FAIL haz_clear got %h exp 00", PEND); end
  endtask

  task automatic test_set_wins();
    idle(); ISSUE = 1; ISSUE_A = 2;
    tick();
    WE = 1; WA = 2; WD = 16'h0011; #1;
    vec++; if (STALL !== 1'b0) begin errs++; $display("FAIL setwin_stall got %b exp 0", STALL); end
    tick();
    idle(); RA2 = 2; #1;
    vec++; if (PEND !== 8'h04 || RD2 !== 16'h0011) begin errs++; $display("FAIL setwin got pend %h rd %h exp 04/0011", PEND, RD2); end
    WE = 1; WA = 2; WD = 16'h0011;
    tick();
    idle(); #1;
    vec++; if (PEND !== 8'h00) begin errs++; $display("FAIL setwin_drain got %h exp 00", PEND); end
  endtask

  task automatic test_waw_async_reset();
    idle(); ISSUE = 1; ISSUE_A = 4;
    tick();
    #1;
    vec++; if (STALL !== 1'b1) begin errs++; $display("FAIL waw_stall got %b exp 1", STALL); end
    tick();
    vec++; if (PEND !== 8'h10) begin errs++; $display("FAIL waw_hold got %h exp 10", PEND); end
    RA1 = 3; #1;
    rst_n = 0; model_reset(); #1;
    vec++; if (PEND !== 8'h00 || STALL !== 1'b0) begin errs++; $display("FAIL async_rst got %h/%b exp 00/0", PEND, STALL); end
    vec++; if (RD1 !== 16'h0000) begin errs++; $display("FAIL async_rst_rd got %h exp 0000", RD1); end
    // a write presented during reset must not land
    idle(); WE = 1; WA = 6; WD = 16'h5555;
    @(posedge clk); @(negedge clk);
    WE = 0; rst_n = 1; RA1 = 6; #1;
    vec++; if (RD1 !== 16'h0000) begin errs++; $display("FAIL rst_write got %h exp 0000", RD1); end
    WE = 1; WA = 6; WD = 16'h6666;
    tick();
    WE = 0; #1;
    vec++; if (RD1 !== 16'h6666) begin errs++; $display("FAIL first_write got %h exp 6666", RD1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      RA1 = 3'($urandom); RA2 = 3'($urandom);
      WE = ($urandom_range(0, 2) != 0); WA = 3'($urandom); WD = 16'($urandom);
      ISSUE = ($urandom_range(0, 1) == 1); ISSUE_A = 3'($urandom);
      #1;
      vec++; if (RD1 !== exp_rd(RA1) || RD2 !== exp_rd(RA2)) begin
        errs++; $display("FAIL rnd_rd got %h/%h exp %h/%h", RD1, RD2, exp_rd(RA1), exp_rd(RA2)); end
      vec++; if (HAZ1 !== exp_haz(RA1) || HAZ2 !== exp_haz(RA2) || STALL !== exp_stall()) begin
        errs++; $display("FAIL rnd_haz got %b%b%b exp %b%b%b", HAZ1, HAZ2, STALL, exp_haz(RA1), exp_haz(RA2), exp_stall()); end
      tick();
      vec++; if (PEND !== m_p) begin errs++; $display("FAIL rnd_pend got %h exp %h", PEND, m_p); end
    end
  endtask

  initial begin
    idle(); rst_n = 1; model_reset();
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_hazard();
    test_set_wins();
    test_waw_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The module SHALL have port `clk`: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-002 The module SHALL have port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 The module SHALL have port `RA1`: input, 3 bits, read address for port 1.
REQ-004 The module SHALL have port `RA2`: input, 3 bits, read address for port 2.
REQ-005 The module SHALL have port `RD1`: output, 16 bits, read data for port 1 (combinational).
REQ-006 The module SHALL have port `RD2`: output, 16 bits, read data for port 2 (combinational).
REQ-007 The module SHALL have port `WA`: input, 3 bits, write-back address, driven by the upstream 3-bit 2:1 destination select.
REQ-008 The module SHALL have port `WD`: input, 16 bits, write-back data.
REQ-009 The module SHALL have port `WE`: input, 1 bit, write-back enable.
REQ-010 The module SHALL have port `ISSUE`: input, 1 bit, an instruction claims destination `ISSUE_A` this cycle.
REQ-011 The module SHALL have port `ISSUE_A`: input, 3 bits, destination being claimed.
REQ-012 The module SHALL have port `HAZ1`: output, 1 bit, RA1 is pending and is not satisfied by a same-cycle write.
REQ-013 The module SHALL have port `HAZ2`: output, 1 bit, same as HAZ1 for RA2.
REQ-014 The module SHALL have port `STALL`: output, 1 bit, upstream must hold the current instruction.
REQ-015 The module SHALL have port `PEND`: output, 8 bits, scoreboard pending vector (bit n = Rn).

Function
REQ-016 The storage SHALL consist of 8 registers of 16 bits each; R0 reads 0, writes to R0 are discarded, and PEND[0] is constant 0.
REQ-017 A write SHALL occur at the rising edge when WE=1 and WA!=0: R[WA] <= WD; one-cycle write latency.
REQ-018 Reads SHALL be combinational with zero latency: RDn = 0 if RAn=0; else WD if WE=1 and WA=RAn (write-through bypass); else R[RAn].
REQ-019 Scoreboard set: at the clock edge, when ISSUE=1, ISSUE_A!=0 and STALL=0, PEND[ISSUE_A] <= 1.
REQ-020 Scoreboard clear: at the clock edge, when WE=1 and WA!=0, PEND[WA] <= 0.
REQ-021 When a set and a clear target the same register in the same cycle, the set SHALL win (PEND stays 1, reflecting the new producer), while the data write still occurs.
REQ-022 Set and clear on different registers in the same cycle SHALL both take effect.
REQ-023 HAZn SHALL be computed as PEND[RAn] & ~(WE & (WA==RAn)); HAZn SHALL be 0 whenever RAn=0.
REQ-024 STALL SHALL be computed as HAZ1 | HAZ2 | (ISSUE & PEND[ISSUE_A] & ~(WE & WA==ISSUE_A)), i.e. a WAW on an uncleared destination stalls.
REQ-025 STALL SHALL have no effect on writes: WE is always honoured, because write-back is never blocked.
REQ-026 HAZ1, HAZ2 and STALL SHALL be combinational only, with no registered outputs other than PEND.

Reset
REQ-027 When rst_n=0, asynchronously: all registers SHALL be 0x0000, PEND SHALL be 0x00, and hence RD1=RD2=0 (absent bypass), HAZ1=HAZ2=0 and STALL=ISSUE-independent 0.
REQ-028 Reset asserted mid-operation SHALL discard pending claims and register contents immediately, without waiting for a clock edge.
REQ-029 The first write accepted after deassertion SHALL be the one at the first rising edge with rst_n=1.

Verification
REQ-030 Reset, then apply WE=1, WA=3, WD=0xBEEF for one edge, then RA1=3, so that RD1=0xBEEF; with RA2=0, RD2=0x0000.
REQ-031 Apply WE=1, WA=0, WD=0x1234, then RA1=0, so that RD1=0x0000 and PEND[0]=0.
REQ-032 Within the same cycle set WE=1, WA=5, WD=0x00AA and RA1=5, so that RD1=0x00AA before the edge (bypass).
REQ-033 Apply ISSUE=1, ISSUE_A=2 at an edge and then RA1=2, WE=0, so that PEND=0x04, HAZ1=1 and STALL=1; next cycle set WE=1, WA=2, so that HAZ1=0 that cycle and PEND=0x00 after the edge.
REQ-034 With PEND=0x04, apply ISSUE=1, ISSUE_A=2 together with WE=1, WA=2, WD=0x0011, so that STALL=0, R2=0x0011 and PEND=0x04 after the edge (set wins).
REQ-035 With PEND=0x10, apply ISSUE=1, ISSUE_A=4, WE=0, so that STALL=1 and PEND is unchanged; then assert rst_n=0 mid-cycle, so that PEND=0x00 and STALL=0 without a clock edge.
